// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with valid-qualified input, run-time
// pattern/length/overlap configuration and a saturating match counter.
module seq_detect_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b1,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inp_bit,
    input  logic               inp_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               seen_q, seen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;

    logic               accept;
    logic               match;
    logic               fill_ok;
    logic [LEN_W:0]     fill_p1;
    logic [MAX_LEN-1:0] ext;
    logic [MAX_LEN-1:0] mask;

    // Only the newest len bits of {hist, inp_bit} take part in the compare.
    always_comb begin
        accept  = inp_valid & ~cfg_load;
        ext     = {hist_q[MAX_LEN-2:0], inp_bit};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        fill_p1 = {1'b0, fill_q} + (LEN_W + 1)'(1);
        fill_ok = (fill_p1 >= {1'b0, len_q});
        match   = accept && (len_q != '0) && fill_ok && (((ext ^ pat_q) & mask) == '0);
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        seen_d = match;
        cnt_d  = cnt_q;

        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d = ext;
            fill_d = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
            // Non-overlap mode only needs fill reset; stale hist bits are masked by fill.
            if (match && !ovl_q) begin
                fill_d = '0;
            end
        end

        if (clr_count) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        sat_d = (cnt_d == '1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEF_PATTERN;
            len_q  <= (DEF_LEN_L > MAX_LEN_L) ? MAX_LEN_L : DEF_LEN_L;
            ovl_q  <= DEF_OVERLAP;
            seen_q <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            seen_q <= seen_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    assign seq_seen    = seen_q;
    assign match_count = cnt_q;
    assign count_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: a queue-based model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               inp_bit = 1'b0;
    logic               inp_valid = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               clr_count = 1'b0;
    logic               seq_seen;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;

    seq_detect_prog #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .inp_bit    (inp_bit),
        .inp_valid  (inp_valid),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .clr_count  (clr_count),
        .seq_seen   (seq_seen),
        .match_count(match_count),
        .count_sat  (count_sat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: accepted bits since the last clear, newest at the back.
    bit             m_q[$];
    bit [7:0]       m_pat;
    int             m_len;
    bit             m_ovl;
    int             m_cnt;
    bit             exp_seen = 1'b0;
    int             exp_cnt = 0;
    bit             exp_sat = 1'b0;
    bit             run = 1'b0;

    task model_edge();
        bit m;
        m = 1'b0;
        if (reset) begin
            m_q.delete();
            m_pat = 8'b0000_1011;
            m_len = 4;
            m_ovl = 1'b1;
            m_cnt = 0;
        end else begin
            if (cfg_load) begin
                m_pat = cfg_pattern;
                m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
                m_ovl = cfg_overlap;
                m_q.delete();
            end else if (inp_valid) begin
                m_q.push_back(inp_bit);
                if (m_len > 0 && m_q.size() >= m_len) begin
                    m = 1'b1;
                    for (int k = 0; k < m_len; k++) begin
                        if (m_q[m_q.size() - 1 - k] != m_pat[k]) m = 1'b0;
                    end
                end
                if (m && !m_ovl) m_q.delete();
                if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
            end
            if (clr_count) m_cnt = m ? 1 : 0;
            else if (m && m_cnt < CNT_MAX) m_cnt++;
        end
        exp_seen = m;
        exp_cnt  = m_cnt;
        exp_sat  = (m_cnt == CNT_MAX);
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("cyc_seq_seen", int'(seq_seen), int'(exp_seen));
            chk("cyc_match_count", int'(match_count), exp_cnt);
            chk("cyc_count_sat", int'(count_sat), int'(exp_sat));
        end
    end

    task tick();
        @(posedge clk);
        model_edge();
        run = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        inp_valid = 1'b0;
        cfg_load  = 1'b0;
        clr_count = 1'b0;
    endtask

    task bitin(input bit b);
        inp_valid = 1'b1;
        inp_bit   = b;
        tick();
    endtask

    task load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input bit o);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        tick();
    endtask

    task do_reset();
        reset = 1'b1;
        tick();
    endtask

    task do_clr();
        clr_count = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_seq_seen", int'(seq_seen), 0);
        chk("rst_match_count", int'(match_count), 0);
        chk("rst_count_sat", int'(count_sat), 0);

        // Defaults 1011, overlapping: 1,0,1,1,0,1,1
        bitin(1); bitin(0); bitin(1); bitin(1);
        chk("t1_pulse_bit4", int'(seq_seen), 1);
        bitin(0);
        chk("t1_quiet_bit5", int'(seq_seen), 0);
        bitin(1); bitin(1);
        chk("t1_pulse_bit7", int'(seq_seen), 1);
        chk("t1_count", int'(match_count), 2);
        do_clr();
        chk("clr_count_zero", int'(match_count), 0);

        // 101, non-overlap then overlap
        load(8'b101, 4'd3, 1'b0);
        bitin(1); bitin(0); bitin(1);
        chk("t2a_pulse_bit3", int'(seq_seen), 1);
        bitin(0); bitin(1);
        chk("t2a_quiet_bit5", int'(seq_seen), 0);
        chk("t2a_count", int'(match_count), 1);
        do_clr();
        load(8'b101, 4'd3, 1'b1);
        bitin(1); bitin(0); bitin(1);
        chk("t2b_pulse_bit3", int'(seq_seen), 1);
        bitin(0); bitin(1);
        chk("t2b_pulse_bit5", int'(seq_seen), 1);
        chk("t2b_count", int'(match_count), 2);

        // Gaps of three idle cycles between bits
        do_reset();
        bitin(1); tick(); tick(); tick();
        bitin(0); tick(); tick(); tick();
        bitin(1); tick(); tick(); tick();
        bitin(1);
        chk("t3_pulse_after_gaps", int'(seq_seen), 1);
        tick();
        chk("t3_quiet_in_gap", int'(seq_seen), 0);
        chk("t3_count", int'(match_count), 1);

        // Counter saturation with a length-1 pattern
        do_clr();
        load(8'b1, 4'd1, 1'b1);
        bitin(1); chk("t4_count1", int'(match_count), 1); chk("t4_sat1", int'(count_sat), 0);
        bitin(1); chk("t4_count2", int'(match_count), 2); chk("t4_sat2", int'(count_sat), 0);
        bitin(1); chk("t4_count3", int'(match_count), 3); chk("t4_sat3", int'(count_sat), 1);
        bitin(1); chk("t4_count4", int'(match_count), 3);
        bitin(1); chk("t4_count5", int'(match_count), 3); chk("t4_sat5", int'(count_sat), 1);
        clr_count = 1'b1;
        bitin(1);
        chk("t4_clr_with_match", int'(match_count), 1);
        chk("t4_sat_after_clr", int'(count_sat), 0);

        // Load in mid-stream drops the concurrent bit and clears history
        do_reset();
        bitin(1); bitin(0); bitin(1);
        inp_valid = 1'b1;
        inp_bit   = 1'b1;
        load(8'b1011, 4'd4, 1'b1);
        bitin(1);
        chk("t5_no_pulse_after_load", int'(seq_seen), 0);
        bitin(0); bitin(1); bitin(1);
        chk("t5_pulse_fresh", int'(seq_seen), 1);

        // Reset mid-stream
        do_reset();
        bitin(1); bitin(0); bitin(1);
        do_reset();
        bitin(1);
        chk("t6_no_pulse_after_reset", int'(seq_seen), 0);
        bitin(0); bitin(1); bitin(1);
        chk("t6_defaults_restored", int'(seq_seen), 1);
        chk("t6_count", int'(match_count), 1);

        // len=0 never matches
        load(8'b1011, 4'd0, 1'b1);
        bitin(1); bitin(0); bitin(1); bitin(1);
        chk("len0_no_pulse", int'(seq_seen), 0);
        bitin(1); bitin(1);
        chk("len0_count", int'(match_count), 1);

        // len=12 clamps to 8
        do_clr();
        load(8'b1010_0110, 4'd12, 1'b1);
        bitin(1); bitin(0); bitin(1); bitin(0);
        chk("len12_no_early_pulse", int'(seq_seen), 0);
        bitin(0); bitin(1); bitin(1); bitin(0);
        chk("len12_pulse_bit8", int'(seq_seen), 1);
        chk("len12_count", int'(match_count), 1);

        tick();
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
